// File: rtl/seq_ctrl_decoder_pkg.sv
// Shared opcode, ALU-select and FSM-state encodings for seq_ctrl_decoder.
// The optional HALT opcode is enabled with SEQ_CTRL_DECODER_HALT_EN.
package seq_ctrl_decoder_pkg;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_HALT     = 4'b1000;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC_IM   = 4'b1110;
  localparam logic [3:0] OP_JMP_IM   = 4'b1111;

  localparam logic [1:0] SEL_Z = 2'd0;
  localparam logic [1:0] SEL_A = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;
  localparam logic [1:0] SEL_I = 2'd3;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef struct packed {
    logic [1:0] sel;
    logic       a_load;
    logic       b_load;
    logic       pc_load;
    logic       io_load;
    logic       halt;
  } dec_t;

  // ADD opcodes are the only ones whose commit captures the ALU carry.
  function automatic logic op_updates_carry(input logic [3:0] op);
    return (op == OP_ADD_A_IM) || (op == OP_ADD_B_IM);
  endfunction

endpackage

// File: rtl/seq_ctrl_decoder_op_decode_rom.sv
// Combinational opcode + carry -> {sel, loads, halt} table; ungated by commit.
// Opcode 1000 decodes to HALT only when SEQ_CTRL_DECODER_HALT_EN is defined.
module op_decode_rom
  import seq_ctrl_decoder_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       carry_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o     = '0;
    dec_o.sel = SEL_Z;
    unique case (opcode_i)
      OP_ADD_A_IM: begin dec_o.sel = SEL_A; dec_o.a_load = 1'b1; end
      OP_MOV_A_B:  begin dec_o.sel = SEL_B; dec_o.a_load = 1'b1; end
      OP_IN_A:     begin dec_o.sel = SEL_I; dec_o.a_load = 1'b1; end
      OP_MOV_A_IM: begin dec_o.sel = SEL_Z; dec_o.a_load = 1'b1; end
      OP_MOV_B_A:  begin dec_o.sel = SEL_A; dec_o.b_load = 1'b1; end
      OP_ADD_B_IM: begin dec_o.sel = SEL_B; dec_o.b_load = 1'b1; end
      OP_IN_B:     begin dec_o.sel = SEL_I; dec_o.b_load = 1'b1; end
      OP_MOV_B_IM: begin dec_o.sel = SEL_Z; dec_o.b_load = 1'b1; end
      OP_OUT_B:    begin dec_o.sel = SEL_B; dec_o.io_load = 1'b1; end
      OP_OUT_IM:   begin dec_o.sel = SEL_Z; dec_o.io_load = 1'b1; end
      OP_JMP_IM:   dec_o.pc_load = 1'b1;
      OP_JNC_IM:   dec_o.pc_load = ~carry_i;
`ifdef SEQ_CTRL_DECODER_HALT_EN
      OP_HALT:     dec_o.halt = 1'b1;
`endif
      default:     dec_o.sel = SEL_Z;
    endcase
  end

endmodule

// File: rtl/seq_ctrl_decoder.sv
// Multi-cycle instruction decoder: FETCH handshake -> IR -> EXEC commit strobes.
// Define SEQ_CTRL_DECODER_HALT_EN to enable the HALT opcode and state.
module seq_ctrl_decoder
  import seq_ctrl_decoder_pkg::*;
#(
  parameter int IMM_W = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [IMM_W+3:0]   instr_in,
  input  logic               alu_carry,
  input  logic               stall,
  output logic [SEL_W-1:0]   alu_data_sel,
  output logic [IMM_W-1:0]   imm_out,
  output logic               reg_a_load,
  output logic               reg_b_load,
  output logic               reg_pc_load,
  output logic               reg_io_load,
  output logic               reg_pc_inc,
  output logic               carry_flag,
  output logic               halted
);

  localparam int IW = IMM_W + 4;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          carry_q, carry_d;
  logic [3:0]    opcode;
  logic          in_exec, commit;
  dec_t          dec;

  assign opcode = ir_q[IW-1 -: 4];

  op_decode_rom u_rom (
    .opcode_i (opcode),
    .carry_i  (carry_q),
    .dec_o    (dec)
  );

  assign in_exec = (state_q == ST_EXEC);
  // Reset masks the commit so no strobe escapes during the reset cycle.
  assign commit  = in_exec && !stall && !reset;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          carry_d = op_updates_carry(opcode) ? alu_carry : 1'b0;
          state_d = dec.halt ? ST_HALT : ST_FETCH;
        end
      end
`ifdef SEQ_CTRL_DECODER_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  assign instr_ready  = (state_q == ST_FETCH) && !reset;
  assign alu_data_sel = in_exec ? SEL_W'(dec.sel) : SEL_W'(SEL_Z);
  assign imm_out      = ir_q[IMM_W-1:0];
  assign reg_a_load   = commit & dec.a_load;
  assign reg_b_load   = commit & dec.b_load;
  assign reg_pc_load  = commit & dec.pc_load;
  assign reg_io_load  = commit & dec.io_load;
  assign reg_pc_inc   = commit & ~dec.pc_load & ~dec.halt;
  assign carry_flag   = carry_q;

`ifdef SEQ_CTRL_DECODER_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_seq_ctrl_decoder.sv
// Directed self-checking bench for seq_ctrl_decoder (IMM_W=4, SEL_W=2).
module tb_seq_ctrl_decoder;

  logic       clk = 1'b0;
  logic       reset, instr_valid, alu_carry, stall;
  logic [7:0] instr_in;
  logic       instr_ready, reg_a_load, reg_b_load, reg_pc_load, reg_io_load;
  logic       reg_pc_inc, carry_flag, halted;
  logic [1:0] alu_data_sel;
  logic [3:0] imm_out;

  int tests = 0;
  int fails = 0;

  seq_ctrl_decoder #(.IMM_W(4), .SEL_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_in     (instr_in),
    .alu_carry    (alu_carry),
    .stall        (stall),
    .alu_data_sel (alu_data_sel),
    .imm_out      (imm_out),
    .reg_a_load   (reg_a_load),
    .reg_b_load   (reg_b_load),
    .reg_pc_load  (reg_pc_load),
    .reg_io_load  (reg_io_load),
    .reg_pc_inc   (reg_pc_inc),
    .carry_flag   (carry_flag),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // {sel[1:0], a, b, pc, io, inc}
  function automatic logic [6:0] obs();
    return {alu_data_sel, reg_a_load, reg_b_load, reg_pc_load, reg_io_load, reg_pc_inc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Inputs change just after negedge; checks follow #1 later in the low phase.
  task automatic tick();
    @(negedge clk);
  endtask

  // Accept one word from FETCH; returns in the first EXEC cycle with valid dropped.
  task automatic issue(input logic [7:0] w);
    instr_valid = 1'b1; instr_in = w;
    tick();
    instr_valid = 1'b0;
  endtask

  logic [6:0] exp_tab [16];

  initial begin
    exp_tab[0]  = {2'd1, 5'b10001};
    exp_tab[1]  = {2'd2, 5'b10001};
    exp_tab[2]  = {2'd3, 5'b10001};
    exp_tab[3]  = {2'd0, 5'b10001};
    exp_tab[4]  = {2'd1, 5'b01001};
    exp_tab[5]  = {2'd2, 5'b01001};
    exp_tab[6]  = {2'd3, 5'b01001};
    exp_tab[7]  = {2'd0, 5'b01001};
    exp_tab[8]  = {2'd0, 5'b00001};
    exp_tab[9]  = {2'd2, 5'b00011};
    exp_tab[10] = {2'd0, 5'b00001};
    exp_tab[11] = {2'd0, 5'b00011};
    exp_tab[12] = {2'd0, 5'b00001};
    exp_tab[13] = {2'd0, 5'b00001};
    exp_tab[14] = {2'd0, 5'b00100};
    exp_tab[15] = {2'd0, 5'b00100};

    reset = 1'b1; instr_valid = 1'b0; instr_in = 8'h00; alu_carry = 1'b0; stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_strobes", obs(), 7'h00);
    chk("rst_carry", carry_flag, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imm", imm_out, 0);

    // Reset while stalled in EXEC.
    issue(8'h12); stall = 1'b1;
    #1;
    chk("stall_ready", instr_ready, 0);
    chk("stall_strobes", obs(), {2'd2, 5'b00000});
    reset = 1'b1;
    tick(); reset = 1'b0;
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_strobes", obs(), 7'h00);
    chk("midrst_carry", carry_flag, 0);
    stall = 1'b0;

    // MOV A,5 with valid held through EXEC: one-cycle strobe.
    instr_valid = 1'b1; instr_in = 8'h35;
    tick();
    #1;
    chk("mov_strobes", obs(), {2'd0, 5'b10001});
    chk("mov_imm", imm_out, 5);
    chk("mov_ready", instr_ready, 0);
    tick(); instr_valid = 1'b0;
    #1;
    chk("mov_oneshot", obs(), 7'h00);
    chk("mov_back_fetch", instr_ready, 1);

    // ADD A with carry, then JNC not taken, MOV, JNC taken.
    issue(8'h03); alu_carry = 1'b1;
    #1;
    chk("add_strobes", obs(), {2'd1, 5'b10001});
    tick(); alu_carry = 1'b0;
    #1;
    chk("add_carry", carry_flag, 1);
    issue(8'hE7);
    #1;
    chk("jnc_nt", obs(), {2'd0, 5'b00001});
    chk("jnc_nt_imm", imm_out, 7);
    tick();
    #1;
    chk("jnc_clr_carry", carry_flag, 0);
    issue(8'h31); tick();
    issue(8'hE7);
    #1;
    chk("jnc_t", obs(), {2'd0, 5'b00100});
    chk("jnc_t_imm", imm_out, 7);
    tick();

    // Decode table sweep with carry_flag=0 (opcode 8 handled at the end).
    for (int op = 0; op < 16; op++) begin
      if (op != 8) begin
        issue({op[3:0], 4'h0});
        #1;
        chk($sformatf("dec_op%0d", op), obs(), exp_tab[op]);
        tick();
      end
    end

    // Carry=1, then OUT B stalled for 3 cycles.
    issue(8'h50); alu_carry = 1'b1;
    tick(); alu_carry = 1'b0;
    #1;
    chk("addb_carry", carry_flag, 1);
    issue(8'h9A); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("outb_stall%0d", i), obs(), {2'd2, 5'b00000});
      tick();
    end
    stall = 1'b0;
    #1;
    chk("outb_commit", obs(), {2'd2, 5'b00011});
    chk("outb_carry_hold", carry_flag, 1);
    tick();
    #1;
    chk("outb_carry_clr", carry_flag, 0);

    // Valid during EXEC with another word is ignored.
    issue(8'h3C); stall = 1'b1; instr_valid = 1'b1; instr_in = 8'h7F;
    #1;
    chk("ign_imm0", imm_out, 4'hC);
    tick();
    #1;
    chk("ign_imm1", imm_out, 4'hC);
    stall = 1'b0; instr_valid = 1'b0;
    #1;
    chk("ign_commit", obs(), {2'd0, 5'b10001});
    tick();
    #1;
    chk("ign_ir_kept", imm_out, 4'hC);
    chk("ign_ready", instr_ready, 1);

    // Opcode 1000.
    issue(8'h80);
    #1;
`ifdef SEQ_CTRL_DECODER_HALT_EN
    chk("halt_commit", obs(), 7'h00);
    tick();
    instr_valid = 1'b1; instr_in = 8'h35;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("halt_hold%0d", i), {halted, instr_ready, reg_a_load, reg_pc_inc}, 4'b1000);
      tick();
    end
    instr_valid = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    #1;
    chk("halt_rst", {halted, instr_ready}, 2'b01);
`else
    chk("nop8_commit", obs(), {2'd0, 5'b00001});
    tick();
    #1;
    chk("nop8_after", {halted, instr_ready}, 2'b01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
